// File: rtl/vga_tile_pkg.sv
// Shared definitions for the VGA tile line fetcher: default widths and the
// prefetch FSM state encoding.
package vga_tile_pkg;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_PIC_W   = 9;
    localparam int DEF_X_TILES = 32;
    localparam int DEF_XW      = 5;
    localparam int DEF_YW      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        REQ  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/vga_line_buffer.sv
// Ping-pong line buffer: two banks of X_TILES entries. One bank is written by
// the prefetcher while the other is read by the bit generator through a
// registered read port (1-cycle latency, out-of-range index reads as 0).
module vga_line_buffer
    import vga_tile_pkg::*;
#(
    parameter int ENTRY_W = DEF_PIC_W,
    parameter int X_TILES = DEF_X_TILES,
    parameter int XW      = DEF_XW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic               wr_bank,
    input  logic [XW-1:0]      wr_idx,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic               rd_bank,
    input  logic [XW-1:0]      rd_idx,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] bank0 [X_TILES];
    logic [ENTRY_W-1:0] bank1 [X_TILES];
    logic               rd_in_range;

    assign rd_in_range = (32'(rd_idx) < 32'(X_TILES));

    // Storage write: contents carry no reset, only the back bank is written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_bank) begin
                bank1[wr_idx] <= wr_data;
            end else begin
                bank0[wr_idx] <= wr_data;
            end
        end
    end

    // Registered read from the front bank; indices past the row read as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (!rd_in_range) begin
            rd_data <= '0;
        end else if (rd_bank) begin
            rd_data <= bank1[rd_idx];
        end else begin
            rd_data <= bank0[rd_idx];
        end
    end

endmodule

// File: rtl/vga_tile_line_fetcher.sv
// VGA tile line fetcher: prefetches one row of tile numbers into the back half
// of a ping-pong line buffer over a req/ack memory port while the bit
// generator reads the front half. Optional macro VGA_TILE_ATTR_EN keeps the
// upper memory data bits as per-tile attributes and exposes them on pic_attr.
//
// Memory handshake: mem_req/mem_addr are driven from registers; a word is
// transferred in any cycle where mem_req and mem_ack are both high, with
// mem_data valid in that same cycle. mem_addr only moves after an accepted word.
module vga_tile_line_fetcher
    import vga_tile_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PIC_W   = DEF_PIC_W,
    parameter int X_TILES = DEF_X_TILES,
    parameter int XW      = DEF_XW,
    parameter int YW      = DEF_YW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] start_address,
    input  logic [ADDR_W-1:0] row_length,
    input  logic [YW-1:0]     load_row,
    input  logic              line_load,
    input  logic              line_swap,
    input  logic [XW-1:0]     x_sup_pix,
    output logic [PIC_W-1:0]  pic_num,
`ifdef VGA_TILE_ATTR_EN
    output logic [DATA_W-PIC_W-1:0] pic_attr,
`endif
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              underrun
);

    localparam logic [XW-1:0] LAST_IDX = XW'(X_TILES - 1);

`ifdef VGA_TILE_ATTR_EN
    localparam int ENTRY_W = DATA_W;
`else
    localparam int ENTRY_W = PIC_W;
`endif

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] row_len_q;
    logic [YW-1:0]     row_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] row_base;
    logic [XW-1:0]     idx_q;
    logic              front_sel;
    logic              back_full;
    logic              last_word;
    logic              accept;
    logic [ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0] rd_data;

    assign busy      = (state != IDLE);
    assign mem_req   = (state == REQ);
    assign last_word = (idx_q == LAST_IDX);
    // A word is only stored when no load or swap redirects the fetch this cycle.
    assign accept    = mem_req && mem_ack && !line_load && !line_swap;
    assign row_base  = start_q + row_len_q * ADDR_W'(row_q);

`ifdef VGA_TILE_ATTR_EN
    assign wr_data  = mem_data;
    assign pic_num  = rd_data[PIC_W-1:0];
    assign pic_attr = rd_data[DATA_W-1:PIC_W];
`else
    logic unused_data_hi;
    assign unused_data_hi = ^mem_data[DATA_W-1:PIC_W];
    assign wr_data  = mem_data[PIC_W-1:0];
    assign pic_num  = rd_data;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a load always restarts address calculation; a swap aborts a fetch.
    always_comb begin
        state_next = state;
        if (line_load) begin
            state_next = CALC;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                CALC:    state_next = REQ;
                REQ: begin
                    if (line_swap || (mem_ack && last_word)) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: buffer roles, fill status, request latching and address stepping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q   <= '0;
            row_len_q <= '0;
            row_q     <= '0;
            base_q    <= '0;
            idx_q     <= '0;
            mem_addr  <= '0;
            front_sel <= 1'b0;
            back_full <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (line_swap) begin
                front_sel <= ~front_sel;
                back_full <= 1'b0;
                if (!back_full) begin
                    underrun <= 1'b1;
                end
            end
            if (line_load) begin
                start_q   <= start_address;
                row_len_q <= row_length;
                row_q     <= load_row;
                idx_q     <= '0;
                back_full <= 1'b0;
            end else if (state == CALC) begin
                base_q   <= row_base;
                mem_addr <= row_base;
            end else if (accept) begin
                if (last_word) begin
                    back_full <= 1'b1;
                end else begin
                    idx_q    <= idx_q + XW'(1);
                    mem_addr <= base_q + ADDR_W'(idx_q) + ADDR_W'(1);
                end
            end
        end
    end

    vga_line_buffer #(
        .ENTRY_W (ENTRY_W),
        .X_TILES (X_TILES),
        .XW      (XW)
    ) u_line_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_bank (~front_sel),
        .wr_idx  (idx_q),
        .wr_data (wr_data),
        .rd_bank (front_sel),
        .rd_idx  (x_sup_pix),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_vga_tile_line_fetcher.sv
// Directed bench for vga_tile_line_fetcher. Memory is modelled as a pure
// function of mem_addr selected by data_mode; inputs change and outputs are
// observed on the falling clock edge.
module tb_vga_tile_line_fetcher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] start_address = '0;
    logic [15:0] row_length = '0;
    logic [3:0]  load_row = '0;
    logic        line_load = 1'b0;
    logic        line_swap = 1'b0;
    logic [4:0]  x_sup_pix = '0;
    logic [8:0]  pic_num;
`ifdef VGA_TILE_ATTR_EN
    logic [6:0]  pic_attr;
`endif
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data;
    logic        busy;
    logic        underrun;

    int checks = 0;
    int passed = 0;
    int data_mode = 0;

    // Memory model: 0 -> low address bits, 1 -> inverted low address bits, 2 -> 0xA405.
    assign mem_data = (data_mode == 0) ? {7'd0, mem_addr[8:0]} :
                      (data_mode == 1) ? {7'd0, mem_addr[8:0] ^ 9'h1FF} :
                      16'hA405;

    always #5 clk = ~clk;

    vga_tile_line_fetcher dut (
        .clk           (clk),
        .reset         (reset),
        .start_address (start_address),
        .row_length    (row_length),
        .load_row      (load_row),
        .line_load     (line_load),
        .line_swap     (line_swap),
        .x_sup_pix     (x_sup_pix),
        .pic_num       (pic_num),
`ifdef VGA_TILE_ATTR_EN
        .pic_attr      (pic_attr),
`endif
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_data      (mem_data),
        .busy          (busy),
        .underrun      (underrun)
    );

    task automatic pulse_load(input logic [15:0] sa, input logic [15:0] rl, input logic [3:0] row);
        start_address = sa;
        row_length    = rl;
        load_row      = row;
        line_load     = 1'b1;
        @(negedge clk);
        line_load     = 1'b0;
    endtask

    task automatic pulse_swap();
        line_swap = 1'b1;
        @(negedge clk);
        line_swap = 1'b0;
    endtask

    // Follows a fetch until busy drops, checking every presented address.
    task automatic track_fetch(input logic [15:0] base, input int period, input string name,
                               output int busy_cycles);
        int k;
        int cyc;
        logic [15:0] exp_addr;
        k = 0;
        cyc = 0;
        busy_cycles = 0;
        while (busy && cyc < 400) begin
            busy_cycles++;
            mem_ack = (period <= 1) || ((cyc % period) == period - 1);
            if (mem_req) begin
                exp_addr = base + 16'(k);
                checks++;
                if (mem_addr !== exp_addr)
                    $display("FAIL %s addr word %0d: got %h expected %h", name, k, mem_addr, exp_addr);
                else
                    passed++;
                if (mem_ack) k++;
            end
            cyc++;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        checks++;
        if (k !== 32 || busy !== 1'b0)
            $display("FAIL %s completion: words %0d busy %b expected 32 words busy 0", name, k, busy);
        else
            passed++;
    endtask

    task automatic check_entry(input int x, input logic [8:0] exp, input string name);
        x_sup_pix = 5'(x);
        @(negedge clk);
        checks++;
        if (pic_num !== exp)
            $display("FAIL %s entry %0d: got %h expected %h", name, x, pic_num, exp);
        else
            passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pic_num !== 9'd0 || mem_req !== 1'b0 || mem_addr !== 16'd0 || busy !== 1'b0 || underrun !== 1'b0)
            $display("FAIL reset_values: pic %h req %b addr %h busy %b underrun %b expected all zero",
                     pic_num, mem_req, mem_addr, busy, underrun);
        else
            passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_release: req %b busy %b expected 0 0", mem_req, busy);
        else
            passed++;
    endtask

    task automatic test_full_row();
        int bc;
        data_mode = 0;
        pulse_load(16'h1000, 16'd40, 4'd3);
        track_fetch(16'h1078, 1, "full_row", bc);
        checks++;
        if (bc !== 33) $display("FAIL full_row busy_cycles: got %0d expected 33", bc);
        else passed++;
        pulse_swap();
        checks++;
        if (underrun !== 1'b0) $display("FAIL full_row underrun: got %b expected 0", underrun);
        else passed++;
        check_entry(5, 9'h07D, "full_row");
        check_entry(0, 9'h078, "full_row");
        check_entry(31, 9'h097, "full_row");
    endtask

    task automatic test_backpressure();
        int bc;
        logic [15:0] a;
        data_mode = 0;
        pulse_load(16'h0200, 16'd7, 4'd5);
        track_fetch(16'h0223, 3, "backpressure", bc);
        pulse_swap();
        for (int i = 0; i < 32; i++) begin
            a = 16'h0223 + 16'(i);
            check_entry(i, a[8:0], "backpressure");
        end
    endtask

    task automatic test_wrap();
        int bc;
        data_mode = 0;
        pulse_load(16'hFFF0, 16'd0, 4'd9);
        track_fetch(16'hFFF0, 1, "wrap", bc);
        pulse_swap();
        check_entry(0, 9'h1F0, "wrap");
        check_entry(15, 9'h1FF, "wrap");
        check_entry(16, 9'h000, "wrap");
        check_entry(31, 9'h00F, "wrap");
    endtask

    task automatic test_underrun();
        int k;
        int cyc;
        data_mode = 1;
        pulse_load(16'h1000, 16'd40, 4'd3);
        mem_ack = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 10 && cyc < 100) begin
            if (mem_req) k++;
            if (k < 10) @(negedge clk);
            cyc++;
        end
        checks++;
        if (k !== 10) $display("FAIL underrun_progress: words %0d expected 10", k);
        else passed++;
        @(negedge clk);
        pulse_swap();
        mem_ack = 1'b0;
        checks++;
        if (underrun !== 1'b1 || busy !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL underrun_swap: underrun %b busy %b req %b expected 1 0 0", underrun, busy, mem_req);
        else
            passed++;
        check_entry(0, 9'h187, "underrun_new");
        check_entry(9, 9'h17E, "underrun_new");
        check_entry(10, 9'h02D, "underrun_stale");
        check_entry(31, 9'h042, "underrun_stale");
        repeat (5) @(negedge clk);
        checks++;
        if (underrun !== 1'b1) $display("FAIL underrun_sticky: got %b expected 1", underrun);
        else passed++;
    endtask

    task automatic test_restart();
        int cyc;
        int bc;
        data_mode = 0;
        pulse_load(16'h1000, 16'd40, 4'd3);
        mem_ack = 1'b1;
        cyc = 0;
        while (!(mem_req === 1'b1 && mem_addr === 16'h107F) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 100) $display("FAIL restart_reach_idx7: addr %h expected 107f", mem_addr);
        else passed++;
        load_row  = 4'd4;
        line_load = 1'b1;
        @(negedge clk);
        line_load = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b1)
            $display("FAIL restart_drop: req %b busy %b expected 0 1", mem_req, busy);
        else
            passed++;
        track_fetch(16'h10A0, 1, "restart", bc);
        pulse_swap();
        check_entry(0, 9'h0A0, "restart");
        check_entry(7, 9'h0A7, "restart");
        check_entry(31, 9'h0BF, "restart");
    endtask

    task automatic test_simultaneous();
        int bc;
        data_mode = 1;
        line_swap = 1'b1;
        pulse_load(16'h0300, 16'd1, 4'd2);
        line_swap = 1'b0;
        track_fetch(16'h0302, 1, "simul", bc);
        check_entry(0, 9'h187, "simul_front_kept");
        check_entry(31, 9'h042, "simul_front_kept");
        pulse_swap();
        check_entry(0, 9'h0FD, "simul_loaded");
        check_entry(31, 9'h0DE, "simul_loaded");
    endtask

`ifdef VGA_TILE_ATTR_EN
    task automatic test_attr();
        int bc;
        data_mode = 2;
        pulse_load(16'h0000, 16'd0, 4'd0);
        track_fetch(16'h0000, 1, "attr", bc);
        pulse_swap();
        check_entry(3, 9'h005, "attr_pic");
        checks++;
        if (pic_attr !== 7'h52) $display("FAIL attr_value: got %h expected 52", pic_attr);
        else passed++;
    endtask
`endif

    task automatic test_reset_mid_req();
        data_mode = 0;
        pulse_load(16'h1000, 16'd40, 4'd3);
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) $display("FAIL midreq_setup: req %b expected 1", mem_req);
        else passed++;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || underrun !== 1'b0 || mem_addr !== 16'd0 || pic_num !== 9'd0)
            $display("FAIL midreq_async_reset: req %b busy %b underrun %b addr %h pic %h expected all zero",
                     mem_req, busy, underrun, mem_addr, pic_num);
        else
            passed++;
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b0 || busy !== 1'b0)
                $display("FAIL midreq_no_resume: req %b busy %b expected 0 0", mem_req, busy);
            else
                passed++;
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_row();
        test_backpressure();
        test_wrap();
        test_underrun();
        test_restart();
        test_simultaneous();
`ifdef VGA_TILE_ATTR_EN
        test_attr();
`endif
        test_reset_mid_req();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
